// File: rtl/ipl_irq_scheduler.sv
// Interrupt-level scheduler: turns synchronized 68000 IPL changes into a
// request/acknowledge handshake with hold-off, coalescing, NMI edge latch and timeout.
module ipl_irq_scheduler #(
  parameter int MIN_GAP = 4,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [2:0] IPL,
  input  logic       ACK,
  input  logic       NMI_CLR,
  output logic       IRQ_OUT,
  output logic [2:0] IRQ_LEVEL,
  output logic       NMI_PENDING,
  output logic       STALE,
  output logic       TIMEOUT_FLAG
);

  localparam int GAP_W    = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam int GAP_INIT = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_INIT);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_GAP} state_t;

  state_t           state_q, state_d;
  logic             irq_out_q, irq_out_d;
  logic [2:0]       irq_level_q, irq_level_d;
  logic [2:0]       prev_level_q, prev_level_d;
  logic             nmi_q, nmi_d;
  logic             stale_q, stale_d;
  logic             tof_q, tof_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       lvl;

  assign lvl = ~IPL;

  always_comb begin
    state_d      = state_q;
    irq_out_d    = irq_out_q;
    irq_level_d  = irq_level_q;
    prev_level_d = lvl;
    nmi_d        = nmi_q;
    stale_d      = stale_q;
    tof_d        = tof_q;
    to_cnt_d     = to_cnt_q;
    gap_d        = gap_q;

    // NMI edge detect runs regardless of ENABLE; a new edge beats a same-cycle clear
    if (prev_level_q != 3'd7 && lvl == 3'd7) begin
      nmi_d = 1'b1;
    end else if (NMI_CLR) begin
      nmi_d = 1'b0;
    end

    if (!ENABLE) begin
      state_d   = S_IDLE;
      irq_out_d = 1'b0;
      to_cnt_d  = '0;
      gap_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lvl != irq_level_q) begin
            irq_level_d = lvl;
            irq_out_d   = 1'b1;
            stale_d     = 1'b0;
            to_cnt_d    = '0;
            state_d     = S_PEND;
          end
        end
        S_PEND: begin
          if (lvl != irq_level_q) stale_d = 1'b1;
          if (ACK) begin
            irq_out_d = 1'b0;
            to_cnt_d  = '0;
            if (MIN_GAP == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_LAST) tof_d = 1'b1;
          end
        end
        S_GAP: begin
          // Level changes here are not tracked; IDLE reports whatever is live then
          if (gap_q == '0) begin
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      irq_out_q    <= 1'b0;
      irq_level_q  <= 3'd0;
      prev_level_q <= 3'd0;
      nmi_q        <= 1'b0;
      stale_q      <= 1'b0;
      tof_q        <= 1'b0;
      to_cnt_q     <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_out_q    <= irq_out_d;
      irq_level_q  <= irq_level_d;
      prev_level_q <= prev_level_d;
      nmi_q        <= nmi_d;
      stale_q      <= stale_d;
      tof_q        <= tof_d;
      to_cnt_q     <= to_cnt_d;
      gap_q        <= gap_d;
    end
  end

  assign IRQ_OUT      = irq_out_q;
  assign IRQ_LEVEL    = irq_level_q;
  assign NMI_PENDING  = nmi_q;
  assign STALE        = stale_q;
  assign TIMEOUT_FLAG = tof_q;

endmodule

// File: tb/tb_ipl_irq_scheduler.sv
// Bench for ipl_irq_scheduler: a default build and a MIN_GAP=0 / short-timeout build
// driven in lockstep, checked against a rule-level model plus directed vectors.
module tb_ipl_irq_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, ack, nmi_clr;
  logic [2:0] ipl;
  logic       irq_a, nmi_a, stale_a, tof_a;
  logic [2:0] lvl_a;
  logic       irq_b, nmi_b, stale_b, tof_b;
  logic [2:0] lvl_b;

  int total = 0;
  int bad   = 0;

  ipl_irq_scheduler #(.MIN_GAP(4), .TIMEOUT(1024), .TO_W(11)) dut_a (
    .CLK(clk), .RESET(rst), .ENABLE(en), .IPL(ipl), .ACK(ack), .NMI_CLR(nmi_clr),
    .IRQ_OUT(irq_a), .IRQ_LEVEL(lvl_a), .NMI_PENDING(nmi_a), .STALE(stale_a),
    .TIMEOUT_FLAG(tof_a));

  ipl_irq_scheduler #(.MIN_GAP(0), .TIMEOUT(5), .TO_W(3)) dut_b (
    .CLK(clk), .RESET(rst), .ENABLE(en), .IPL(ipl), .ACK(ack), .NMI_CLR(nmi_clr),
    .IRQ_OUT(irq_b), .IRQ_LEVEL(lvl_b), .NMI_PENDING(nmi_b), .STALE(stale_b),
    .TIMEOUT_FLAG(tof_b));

  // Rule-level model: a request flag, a count of blocked cycles after ACK,
  // a count of waited cycles, and the sticky flags.
  typedef struct {
    bit       req;
    bit [2:0] lvl;
    int       hold;
    int       waitc;
    bit       stale;
    bit       tof;
    bit       nmi;
    bit [2:0] prev;
  } mstate_t;

  mstate_t m[2];
  int mg[2];
  int tmo[2];

  task automatic model_step(input int i);
    bit [2:0] l;
    l = ~ipl;
    if (rst) begin
      m[i].req = 0; m[i].lvl = 0; m[i].hold = 0; m[i].waitc = 0;
      m[i].stale = 0; m[i].tof = 0; m[i].nmi = 0; m[i].prev = 0;
      return;
    end
    if (m[i].prev != 3'd7 && l == 3'd7) m[i].nmi = 1;
    else if (nmi_clr) m[i].nmi = 0;
    m[i].prev = l;
    if (!en) begin
      m[i].req = 0; m[i].hold = 0; m[i].waitc = 0;
    end else if (m[i].req) begin
      if (l != m[i].lvl) m[i].stale = 1;
      if (ack) begin
        m[i].req  = 0;
        m[i].hold = mg[i];
      end else begin
        if (m[i].waitc < tmo[i]) m[i].waitc++;
        if (m[i].waitc == tmo[i]) m[i].tof = 1;
      end
    end else if (m[i].hold > 0) begin
      m[i].hold--;
    end else if (l != m[i].lvl) begin
      m[i].req = 1; m[i].lvl = l; m[i].stale = 0; m[i].waitc = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("a_irq", 32'(irq_a), 32'(m[0].req));
    chk("a_lvl", 32'(lvl_a), 32'(m[0].lvl));
    chk("a_nmi", 32'(nmi_a), 32'(m[0].nmi));
    chk("a_stale", 32'(stale_a), 32'(m[0].stale));
    chk("a_tof", 32'(tof_a), 32'(m[0].tof));
    chk("b_irq", 32'(irq_b), 32'(m[1].req));
    chk("b_lvl", 32'(lvl_b), 32'(m[1].lvl));
    chk("b_nmi", 32'(nmi_b), 32'(m[1].nmi));
    chk("b_stale", 32'(stale_b), 32'(m[1].stale));
    chk("b_tof", 32'(tof_b), 32'(m[1].tof));
  endtask

  task automatic do_reset();
    rst = 1; en = 0; ack = 0; nmi_clr = 0; ipl = 3'b111;
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    bit       en;
    bit [2:0] ipl;
    bit       ack;
    bit       clr;
    bit       irq;
    bit [2:0] lvl;
    bit       stale;
    bit       nmi;
  } vec_t;

  vec_t tv[23];

  initial begin
    mg[0] = 4; tmo[0] = 1024;
    mg[1] = 0; tmo[1] = 5;

    //          en  ipl    ack clr  irq lvl stale nmi
    tv[0]  = '{1, 3'b111, 0, 0,  0, 3'd0, 0, 0};
    tv[1]  = '{1, 3'b101, 0, 0,  1, 3'd2, 0, 0};
    tv[2]  = '{1, 3'b011, 0, 0,  1, 3'd2, 1, 0};
    tv[3]  = '{1, 3'b001, 0, 0,  1, 3'd2, 1, 0};
    tv[4]  = '{1, 3'b001, 1, 0,  0, 3'd2, 1, 0};
    tv[5]  = '{1, 3'b001, 0, 0,  0, 3'd2, 1, 0};
    tv[6]  = '{1, 3'b001, 0, 0,  0, 3'd2, 1, 0};
    tv[7]  = '{1, 3'b001, 0, 0,  0, 3'd2, 1, 0};
    tv[8]  = '{1, 3'b001, 0, 0,  0, 3'd2, 1, 0};
    tv[9]  = '{1, 3'b001, 0, 0,  1, 3'd6, 0, 0};
    tv[10] = '{1, 3'b001, 1, 0,  0, 3'd6, 0, 0};
    tv[11] = '{1, 3'b010, 0, 0,  0, 3'd6, 0, 0};
    tv[12] = '{1, 3'b000, 0, 0,  0, 3'd6, 0, 1};
    tv[13] = '{1, 3'b000, 0, 1,  0, 3'd6, 0, 0};
    tv[14] = '{1, 3'b001, 0, 0,  0, 3'd6, 0, 0};
    tv[15] = '{1, 3'b000, 0, 1,  1, 3'd7, 0, 1};
    tv[16] = '{1, 3'b000, 1, 0,  0, 3'd7, 0, 1};
    tv[17] = '{1, 3'b111, 0, 0,  0, 3'd7, 0, 1};
    tv[18] = '{1, 3'b111, 0, 0,  0, 3'd7, 0, 1};
    tv[19] = '{1, 3'b111, 0, 0,  0, 3'd7, 0, 1};
    tv[20] = '{1, 3'b111, 0, 0,  0, 3'd7, 0, 1};
    tv[21] = '{1, 3'b111, 0, 0,  1, 3'd0, 0, 1};
    tv[22] = '{1, 3'b111, 1, 0,  0, 3'd0, 0, 1};

    // Reset state, then idle level 0 held for 50 cycles
    do_reset();
    chk("reset_irq", 32'(irq_a), 32'd0);
    chk("reset_lvl", 32'(lvl_a), 32'd0);
    chk("reset_flags", {29'd0, nmi_a, stale_a, tof_a}, 32'd0);
    en = 1; ipl = 3'b111;
    repeat (50) tick();
    chk("idle50_irq", 32'(irq_a), 32'd0);
    chk("idle50_lvl", 32'(lvl_a), 32'd0);

    // Directed vectors: request, coalescing, gap, NMI, return to 0
    for (int i = 0; i < 23; i++) begin
      en = tv[i].en; ipl = tv[i].ipl; ack = tv[i].ack; nmi_clr = tv[i].clr;
      tick();
      chk($sformatf("vec%0d_irq", i), 32'(irq_a), 32'(tv[i].irq));
      chk($sformatf("vec%0d_lvl", i), 32'(lvl_a), 32'(tv[i].lvl));
      chk($sformatf("vec%0d_stale", i), 32'(stale_a), 32'(tv[i].stale));
      chk($sformatf("vec%0d_nmi", i), 32'(nmi_a), 32'(tv[i].nmi));
    end
    ack = 0; nmi_clr = 0;

    // Timeout reached with no ACK; survives a later ACK
    do_reset();
    en = 1; ipl = 3'b111; tick();
    ipl = 3'b110; tick();
    chk("to_req", 32'(irq_a), 32'd1);
    repeat (1023) tick();
    chk("to_1023", 32'(tof_a), 32'd0);
    tick();
    chk("to_1024", 32'(tof_a), 32'd1);
    ack = 1; tick(); ack = 0;
    chk("to_ack_irq", 32'(irq_a), 32'd0);
    chk("to_sticky", 32'(tof_a), 32'd1);

    // ACK on the exact timeout cycle wins
    do_reset();
    en = 1; ipl = 3'b111; tick();
    ipl = 3'b110; tick();
    repeat (1023) tick();
    ack = 1; tick(); ack = 0;
    chk("to_race_flag", 32'(tof_a), 32'd0);
    chk("to_race_irq", 32'(irq_a), 32'd0);
    repeat (3) tick();
    chk("to_race_after", 32'(tof_a), 32'd0);

    // Disable during PEND, re-enable with unchanged level
    do_reset();
    en = 1; ipl = 3'b111; tick();
    ipl = 3'b100; tick();
    chk("dis_req", 32'(irq_a), 32'd1);
    en = 0; tick();
    chk("dis_irq_a", 32'(irq_a), 32'd0);
    chk("dis_irq_b", 32'(irq_b), 32'd0);
    chk("dis_lvl", 32'(lvl_a), 32'd3);
    en = 1; repeat (3) tick();
    chk("reen_irq", 32'(irq_a), 32'd0);

    // Zero-gap build: request one edge after the ACK edge
    ipl = 3'b010; tick();
    chk("g0_req", 32'(irq_b), 32'd1);
    ack = 1; tick(); ack = 0;
    chk("g0_ack", 32'(irq_b), 32'd0);
    ipl = 3'b100; tick();
    chk("g0_next_irq", 32'(irq_b), 32'd1);
    chk("g0_next_lvl", 32'(lvl_b), 32'd3);
    chk("g0_a_in_gap", 32'(irq_a), 32'd0);

    // Reset during PEND drops the request; new request only after a change from 0
    ipl = 3'b001; repeat (6) tick();
    rst = 1; ipl = 3'b111; tick(); rst = 0;
    chk("rstp_irq", 32'(irq_a), 32'd0);
    chk("rstp_lvl", 32'(lvl_a), 32'd0);
    repeat (3) tick();
    chk("rstp_quiet", 32'(irq_a), 32'd0);
    ipl = 3'b100; tick();
    chk("rstp_new", 32'(irq_a), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 19) != 0);
      ack     = ($urandom_range(0, 3) == 0);
      nmi_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) ipl = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 0; ack = 0; nmi_clr = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
